line_frame_sequencer: RTL and testbench
=======================================

# line_frame_sequencer

Parametrised next-generation timing controller for the HoloBlade data path. Watches the fill level of the incoming line buffer, releases one display line at a time to the SLM readout logic through a start/done handshake, counts lines per frame, and signals frame boundaries. Sits between the USB-side buffer and the SLM line driver, clocked on `fpga_clk`. Adds a startup hold, a line index and protocol error flags.

## Interface
Parameters:
- `FILL_WIDTH`, 7: width of `num_words_in_buffer`.
- `WORDS_PER_LINE`, 80: words needed to release a line; legal range 1..2^FILL_WIDTH-1.
- `LINES_PER_FRAME`, 1280: lines per frame; must be ≥1.
- `LINE_CNT_WIDTH`, 11: width of `line_index`; 2^LINE_CNT_WIDTH ≥ LINES_PER_FRAME.
- `STARTUP_CYCLES`, 16: cycles `startup_busy` is held after reset; must be ≥1.

Ports:
- `fpga_clk` in 1: sole clock, rising edge.
- `reset_all` in 1: synchronous, active-high reset.
- `num_words_in_buffer` in FILL_WIDTH: current buffer fill, unsigned.
- `frame_sync` in 1: start-of-frame request, single-cycle pulse.
- `line_start` in 1: downstream accepts the offered line.
- `line_done` in 1: downstream finished reading the line.
- `line_of_data_available` out 1: a full line is ready to read.
- `next_frame_rdy` out 1: idle and ready to accept `frame_sync`.
- `line_index` out LINE_CNT_WIDTH: index of the current or last line.
- `frame_done` out 1: one-cycle pulse after the last line completes.
- `startup_busy` out 1: held high through the startup hold.
- `sync_err` out 1: sticky; `frame_sync` arrived mid-frame.
- `hs_err` out 1: sticky; `line_start` or `line_done` arrived out of protocol.

## Operation
- States: STARTUP, IDLE_FRAME, WAIT_FILL, LINE_READY, LINE_ACTIVE.
- STARTUP: counts `STARTUP_CYCLES`, then moves to IDLE_FRAME.
- IDLE_FRAME: on `frame_sync`, set `line_index` to 0 and move to WAIT_FILL.
- WAIT_FILL: when `num_words_in_buffer` ≥ WORDS_PER_LINE (unsigned compare), move to LINE_READY.
- LINE_READY: on `line_start`, move to LINE_ACTIVE.
- LINE_ACTIVE: on `line_done`:
  - if `line_index` == LINES_PER_FRAME-1: pulse `frame_done`, move to IDLE_FRAME, hold `line_index`;
  - otherwise: increment `line_index`, move to WAIT_FILL.
- Output decode: `line_of_data_available` = (state == LINE_READY); `next_frame_rdy` = (state == IDLE_FRAME); `startup_busy` = (state == STARTUP).
- Error flags:
  - `frame_sync` in any state other than IDLE_FRAME (including STARTUP) is ignored and sets `sync_err`.
  - `line_start` outside LINE_READY, or `line_done` outside LINE_ACTIVE, is ignored and sets `hs_err`.
  - Both flags clear only on reset.
- Fill level is not rechecked after LINE_READY is entered.

## Timing
- All outputs are registered.
- Reset values: state STARTUP, `startup_busy` 1, all other outputs 0, startup counter 0.
- `startup_busy` is high for exactly STARTUP_CYCLES cycles after `reset_all` deasserts. `next_frame_rdy` rises on the following cycle.
- Latency from any qualifying input edge to the resulting output change is 1 cycle. Example: fill reaches threshold in cycle N, so `line_of_data_available` is high from N+1.
- `line_start` sampled high in cycle N: `line_of_data_available` is low from N+1.
- `line_done` in cycle N: `line_index` updates at N+1. If the fill is already sufficient, `line_of_data_available` rises at N+2.
- `frame_done` is high for exactly 1 cycle, coincident with `next_frame_rdy` rising.
- `line_start` and `line_done` in the same cycle are each judged against the current state. Example: in LINE_READY, `line_start` is accepted and `line_done` sets `hs_err`.
- `reset_all` mid-frame aborts immediately: next cycle is STARTUP with reset values and the error flags cleared.

## Configuration
- `LINE_FRAME_SEQ_AUTOSTART_EN` defined:
  - IDLE_FRAME moves to WAIT_FILL after one cycle without `frame_sync`, with `line_index` set to 0 and `next_frame_rdy` high for that single cycle;
  - `frame_sync` is ignored everywhere and never sets `sync_err`.
- Undefined: behaviour as in Operation; a frame starts only on `frame_sync`.

## Test plan
- Reset release with STARTUP_CYCLES=16 -> `startup_busy` high for 16 cycles; `next_frame_rdy` rises on cycle 17; all other outputs 0.
- `frame_sync`, fill=79, then fill=80 in cycle N -> `line_of_data_available` stays low until it rises at N+1; `line_start` drops it the next cycle.
- Full frame with LINES_PER_FRAME=3 -> `line_index` steps 0,1,2; `frame_done` pulses once after the third `line_done`; `next_frame_rdy` rises in the same cycle.
- `frame_sync` during LINE_ACTIVE, and `line_done` during WAIT_FILL -> `sync_err` and `hs_err` set and remain high; state and `line_index` unchanged.
- `reset_all` asserted at `line_index`=1 in LINE_ACTIVE -> next cycle STARTUP, `line_index` 0, flags 0.
- With `LINE_FRAME_SEQ_AUTOSTART_EN` defined, no `frame_sync` -> frames run back-to-back; `next_frame_rdy` is high for 1 cycle between frames.

Source files
------------

// File: rtl/line_frame_sequencer_if.sv
// Buffer-fill / line handshake bundle between the line buffer, the frame
// sequencer and the SLM line driver.
interface line_frame_sequencer_if #(
    parameter int FILL_WIDTH     = 7,
    parameter int LINE_CNT_WIDTH = 11
);
    logic [FILL_WIDTH-1:0]     num_words_in_buffer;
    logic                      frame_sync;
    logic                      line_start;
    logic                      line_done;
    logic                      line_of_data_available;
    logic                      next_frame_rdy;
    logic [LINE_CNT_WIDTH-1:0] line_index;
    logic                      frame_done;
    logic                      startup_busy;
    logic                      sync_err;
    logic                      hs_err;

    modport master (
        output num_words_in_buffer, frame_sync, line_start, line_done,
        input  line_of_data_available, next_frame_rdy, line_index, frame_done,
               startup_busy, sync_err, hs_err
    );

    modport slave (
        input  num_words_in_buffer, frame_sync, line_start, line_done,
        output line_of_data_available, next_frame_rdy, line_index, frame_done,
               startup_busy, sync_err, hs_err
    );
endinterface

// File: rtl/line_frame_sequencer.sv
// Releases buffered display lines one at a time and tracks frame boundaries.
// Define LINE_FRAME_SEQ_AUTOSTART_EN to start frames back-to-back without frame_sync.
module line_frame_sequencer #(
    parameter int FILL_WIDTH      = 7,
    parameter int WORDS_PER_LINE  = 80,
    parameter int LINES_PER_FRAME = 1280,
    parameter int LINE_CNT_WIDTH  = 11,
    parameter int STARTUP_CYCLES  = 16
) (
    input  logic                   fpga_clk,
    input  logic                   reset_all,
    line_frame_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        STARTUP,
        IDLE_FRAME,
        WAIT_FILL,
        LINE_READY,
        LINE_ACTIVE
    } state_t;

    localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [SU_W-1:0]           SU_LAST     = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [LINE_CNT_WIDTH-1:0] LAST_LINE   = LINE_CNT_WIDTH'(LINES_PER_FRAME - 1);
    localparam logic [FILL_WIDTH-1:0]     FILL_NEEDED = FILL_WIDTH'(WORDS_PER_LINE);

    state_t                    state, state_next;
    logic [SU_W-1:0]           su_cnt, su_cnt_next;
    logic [LINE_CNT_WIDTH-1:0] index_q, index_next;
    logic                      frame_done_q, frame_done_next;
    logic                      sync_err_q, sync_err_next;
    logic                      hs_err_q, hs_err_next;
    logic                      ready_q, idle_q, busy_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next      = state;
        su_cnt_next     = su_cnt;
        index_next      = index_q;
        frame_done_next = 1'b0;
        sync_err_next   = sync_err_q;
        hs_err_next     = hs_err_q;

        // Misplaced handshakes are judged against the current state, never acted on.
        if ((bus.line_start && state != LINE_READY) ||
            (bus.line_done  && state != LINE_ACTIVE))
            hs_err_next = 1'b1;
`ifndef LINE_FRAME_SEQ_AUTOSTART_EN
        if (bus.frame_sync && state != IDLE_FRAME)
            sync_err_next = 1'b1;
`endif

        case (state)
            STARTUP: begin
                if (su_cnt == SU_LAST)
                    state_next = IDLE_FRAME;
                else
                    su_cnt_next = su_cnt + 1'b1;
            end
            IDLE_FRAME: begin
`ifdef LINE_FRAME_SEQ_AUTOSTART_EN
                state_next = WAIT_FILL;
                index_next = '0;
`else
                if (bus.frame_sync) begin
                    state_next = WAIT_FILL;
                    index_next = '0;
                end
`endif
            end
            WAIT_FILL: begin
                if (bus.num_words_in_buffer >= FILL_NEEDED)
                    state_next = LINE_READY;
            end
            LINE_READY: begin
                if (bus.line_start)
                    state_next = LINE_ACTIVE;
            end
            LINE_ACTIVE: begin
                if (bus.line_done) begin
                    if (index_q == LAST_LINE) begin
                        state_next      = IDLE_FRAME;
                        frame_done_next = 1'b1;
                    end else begin
                        state_next = WAIT_FILL;
                        index_next = index_q + 1'b1;
                    end
                end
            end
            default: state_next = STARTUP;
        endcase
    end

    // Status outputs are decoded from the next state so they leave a flop directly.
    always_ff @(posedge fpga_clk) begin
        if (reset_all) begin
            state        <= STARTUP;
            su_cnt       <= '0;
            index_q      <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            hs_err_q     <= 1'b0;
            ready_q      <= 1'b0;
            idle_q       <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state        <= state_next;
            su_cnt       <= su_cnt_next;
            index_q      <= index_next;
            frame_done_q <= frame_done_next;
            sync_err_q   <= sync_err_next;
            hs_err_q     <= hs_err_next;
            ready_q      <= (state_next == LINE_READY);
            idle_q       <= (state_next == IDLE_FRAME);
            busy_q       <= (state_next == STARTUP);
        end
    end

    assign bus.line_of_data_available = ready_q;
    assign bus.next_frame_rdy         = idle_q;
    assign bus.startup_busy           = busy_q;
    assign bus.line_index             = index_q;
    assign bus.frame_done             = frame_done_q;
    assign bus.sync_err               = sync_err_q;
    assign bus.hs_err                 = hs_err_q;
endmodule

// File: tb/tb_line_frame_sequencer.sv
// Randomized bench for line_frame_sequencer against a behavioural line/frame model.
module tb_line_frame_sequencer;
    localparam int FILL_WIDTH      = 7;
    localparam int WORDS_PER_LINE  = 80;
    localparam int LINES_PER_FRAME = 3;
    localparam int LINE_CNT_WIDTH  = 11;
    localparam int STARTUP_CYCLES  = 16;

    logic fpga_clk = 1'b0;
    logic reset_all;

    line_frame_sequencer_if #(.FILL_WIDTH(FILL_WIDTH), .LINE_CNT_WIDTH(LINE_CNT_WIDTH)) bus ();

    line_frame_sequencer #(
        .FILL_WIDTH      (FILL_WIDTH),
        .WORDS_PER_LINE  (WORDS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .LINE_CNT_WIDTH  (LINE_CNT_WIDTH),
        .STARTUP_CYCLES  (STARTUP_CYCLES)
    ) dut (
        .fpga_clk  (fpga_clk),
        .reset_all (reset_all),
        .bus       (bus)
    );

    always #5 fpga_clk = ~fpga_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: startup cycles left, whether a frame is running, and where the current line is.
    int m_left;
    bit m_in_frame, m_ready, m_active;
    int m_idx;
    bit m_fd, m_serr, m_herr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_idle();
        return (m_left == 0) && !m_in_frame;
    endfunction

    task automatic model_step(input bit rst, input int fill, input bit fs, input bit ls, input bit ld);
        bit in_startup, idle, waiting;
        if (rst) begin
            m_left = STARTUP_CYCLES;
            m_in_frame = 0; m_ready = 0; m_active = 0;
            m_idx = 0; m_fd = 0; m_serr = 0; m_herr = 0;
            return;
        end
        in_startup = (m_left > 0);
        idle       = m_idle();
        waiting    = m_in_frame && !m_ready && !m_active;
        m_fd = 0;
`ifndef LINE_FRAME_SEQ_AUTOSTART_EN
        if (fs && !idle) m_serr = 1;
`endif
        if (ls && !m_ready)  m_herr = 1;
        if (ld && !m_active) m_herr = 1;
        if (in_startup) begin
            m_left--;
        end else if (idle) begin
`ifdef LINE_FRAME_SEQ_AUTOSTART_EN
            m_in_frame = 1; m_idx = 0;
`else
            if (fs) begin m_in_frame = 1; m_idx = 0; end
`endif
        end else if (waiting) begin
            if (fill >= WORDS_PER_LINE) m_ready = 1;
        end else if (m_ready) begin
            if (ls) begin m_ready = 0; m_active = 1; end
        end else if (m_active && ld) begin
            m_active = 0;
            if (m_idx == LINES_PER_FRAME - 1) begin
                m_in_frame = 0;
                m_fd = 1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic compare_all();
        check("startup_busy", 32'(bus.startup_busy), 32'(m_left > 0));
        check("next_frame_rdy", 32'(bus.next_frame_rdy), 32'(m_idle()));
        check("line_of_data_available", 32'(bus.line_of_data_available), 32'(m_ready));
        check("line_index", 32'(bus.line_index), 32'(m_idx));
        check("frame_done", 32'(bus.frame_done), 32'(m_fd));
        check("sync_err", 32'(bus.sync_err), 32'(m_serr));
        check("hs_err", 32'(bus.hs_err), 32'(m_herr));
    endtask

    task automatic cycle();
        @(posedge fpga_clk);
        model_step(reset_all, int'(bus.num_words_in_buffer), bus.frame_sync, bus.line_start, bus.line_done);
        #1;
        compare_all();
    endtask

    // mode 0: legal protocol; mode 1: legal with rare violations; mode 2: unconstrained
    task automatic drive(input int mode);
        case ($urandom % 4)
            0:       bus.num_words_in_buffer = FILL_WIDTH'(WORDS_PER_LINE - 1);
            1:       bus.num_words_in_buffer = FILL_WIDTH'(WORDS_PER_LINE);
            default: bus.num_words_in_buffer = FILL_WIDTH'($urandom_range(0, 127));
        endcase
        if (mode == 2) begin
            bus.frame_sync = ($urandom % 6 == 0);
            bus.line_start = ($urandom % 6 == 0);
            bus.line_done  = ($urandom % 6 == 0);
            reset_all      = ($urandom % 300 == 0);
        end else begin
            bus.frame_sync = m_idle() && ($urandom % 3 == 0);
            bus.line_start = m_ready && ($urandom % 2 == 0);
            bus.line_done  = m_active && ($urandom % 3 == 0);
            reset_all      = m_active && (m_idx == 1) && ($urandom % 16 == 0);
            if (mode == 1) begin
                if (m_active && $urandom % 40 == 0) bus.frame_sync = 1'b1;
                if (m_in_frame && !m_ready && !m_active && $urandom % 40 == 0) bus.line_done = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        reset_all = 1'b1;
        bus.frame_sync = 1'b0;
        bus.line_start = 1'b0;
        bus.line_done  = 1'b0;
        bus.num_words_in_buffer = '0;
        repeat (3) cycle();
        reset_all = 1'b0;
    endtask

    initial begin
        reset_all = 1'b1;
        bus.frame_sync = 1'b0;
        bus.line_start = 1'b0;
        bus.line_done  = 1'b0;
        bus.num_words_in_buffer = '0;
        m_left = STARTUP_CYCLES;
        for (int mode = 0; mode < 3; mode++) begin
            apply_reset();
            for (int n = 0; n < 2000; n++) begin
                drive(mode);
                cycle();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
